// File: rtl/enc_8to3_scan_pkg.sv
// enc_pkg: shared definitions for the enc_8to3_scan serialising encoder.
//
// Contents:
//   ENC_IN_W / ENC_OUT_W : request vector width and code width
//   state_t              : FSM state encoding (ST_IDLE, ST_SCAN)
//   onehot_to_idx()      : one-hot to binary index lookup, also usable by benches
package enc_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Returns the index of the set bit of a one-hot vector.
  // If more than one bit is set, the highest index wins.
  // An all-zero vector maps to 0.
  function automatic logic [ENC_OUT_W-1:0] onehot_to_idx(input logic [ENC_IN_W-1:0] vec);
    logic [ENC_OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (vec[i]) idx = ENC_OUT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc_8to3_scan_pri_enc8.sv
// pri_enc8: combinational 8-input priority encoder.
//
// Configuration macro: ENC_MSB_FIRST_EN
//   undefined -> the lowest set bit has priority
//   defined   -> the highest set bit has priority
//
// Ports:
//   vec    in  [7:0]  vector to encode
//   idx    out [2:0]  index of the selected (priority) set bit; 0 when vec is zero
//   onehot out [7:0]  the selected bit alone; zero when vec is zero
//   single out        vec has exactly one bit set
module pri_enc8
  import enc_pkg::*;
(
  input  logic [ENC_IN_W-1:0]  vec,
  output logic [ENC_OUT_W-1:0] idx,
  output logic [ENC_IN_W-1:0]  onehot,
  output logic                 single
);

  // The loop visits bits in reverse priority order, so the last set bit
  // it sees (the winner) overwrites any earlier ones.
  always_comb begin
    idx    = '0;
    onehot = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (vec[i]) begin
        idx    = ENC_OUT_W'(i);
        onehot = ENC_IN_W'(1) << i;
      end
    end
`else
    for (int i = ENC_IN_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx    = ENC_OUT_W'(i);
        onehot = ENC_IN_W'(1) << i;
      end
    end
`endif
  end

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  assign single = (vec != '0) && ((vec & (vec - ENC_IN_W'(1))) == '0);

endmodule

// File: rtl/enc_8to3_scan.sv
// enc_8to3_scan: sequential 8-to-3 encoder.
// It accepts an 8-bit request vector over a valid/ready handshake. It then emits
// one 3-bit code per set bit over a second valid/ready handshake.
//
// Configuration macro: ENC_MSB_FIRST_EN
//   Applied inside pri_enc8. When defined, codes come out highest bit first.
//   By default they come out lowest bit first.
//
// Ports:
//   clk        in        system clock, rising edge
//   rst        in        asynchronous active-high reset
//   in_valid   in        in_vec is valid
//   in_ready   out       a vector can be accepted this cycle
//   in_vec     in  [7:0] request vector, bit i means code i
//   out_valid  out       out_code is valid
//   out_ready  in        downstream accepts out_code
//   out_code   out [2:0] index of the current set bit
//   out_last   out       out_code is the final set bit of the vector
//   zero_drop  out       one-cycle pulse: an all-zero vector was accepted and dropped
//   busy       out       high while scanning
module enc_8to3_scan
  import enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ENC_IN_W-1:0]  in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ENC_OUT_W-1:0] out_code,
  output logic                 out_last,
  output logic                 zero_drop,
  output logic                 busy
);

  state_t                state, next_state;
  logic [ENC_IN_W-1:0]   pending, next_pending;
  logic                  next_zero_drop;
  logic [ENC_OUT_W-1:0]  sel_idx;
  logic [ENC_IN_W-1:0]   sel_onehot;
  logic                  sel_single;
  logic                  in_fire, out_fire;

  pri_enc8 u_pri_enc8 (
    .vec    (pending),
    .idx    (sel_idx),
    .onehot (sel_onehot),
    .single (sel_single)
  );

  // All code outputs come only from registered state and pending.
  // pending is kept at zero in IDLE, so out_code and out_last are 0 there.
  assign out_valid = (state == ST_SCAN);
  assign busy      = (state == ST_SCAN);
  assign out_code  = sel_idx;
  assign out_last  = sel_single;
  assign out_fire  = out_valid && out_ready;

  // A new vector is taken on the same edge that retires the final code.
  // This gives back-to-back vectors with no idle cycle in between.
  assign in_ready  = (state == ST_IDLE) || (out_fire && out_last);
  assign in_fire   = in_valid && in_ready;

  // Registered state: FSM state, remaining bits to emit, and the zero-drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      zero_drop <= 1'b0;
    end else begin
      state     <= next_state;
      pending   <= next_pending;
      zero_drop <= next_zero_drop;
    end
  end

  // Next-state logic.
  // In SCAN, each out-handshake retires the selected bit.
  // The final handshake either reloads pending from a freshly accepted vector
  // or returns to IDLE.
  always_comb begin
    next_state     = state;
    next_pending   = pending;
    next_zero_drop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          if (in_vec != '0) begin
            next_pending = in_vec;
            next_state   = ST_SCAN;
          end else begin
            next_zero_drop = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (out_fire) begin
          if (!out_last) begin
            next_pending = pending & ~sel_onehot;
          end else if (in_fire && (in_vec != '0)) begin
            next_pending = in_vec;
          end else begin
            next_pending   = '0;
            next_state     = ST_IDLE;
            next_zero_drop = in_fire;
          end
        end
      end
      default: begin
        next_state   = ST_IDLE;
        next_pending = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_enc_8to3_scan.sv
// tb_enc_8to3_scan: self-checking bench for enc_8to3_scan.
// The reference model is a queue holding the codes still to be emitted.
// Each accepted vector appends its set-bit indices in scan order.
// Each out-handshake pops the head of the queue.
module tb_enc_8to3_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       zero_drop;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   code_q[$];
  logic zd_model = 1'b0;

  enc_8to3_scan dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .zero_drop (zero_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Appends the set-bit indices of vec to the model queue, in scan order.
  task automatic pushCodes(input logic [7:0] vec);
`ifdef ENC_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) if (vec[i]) code_q.push_back(i);
`else
    for (int i = 0; i < 8; i++) if (vec[i]) code_q.push_back(i);
`endif
  endtask

  // One clock cycle:
  //   1. Drive inputs at the falling edge.
  //   2. Check outputs against the model.
  //   3. Advance the model across the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] vec, input logic rdy);
    bit has, last, exp_rdy, fire, acc;
    @(negedge clk);
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
    #1;
    has     = (code_q.size() != 0);
    last    = (code_q.size() == 1);
    exp_rdy = !has || (rdy && last);
    checkOutput("out_valid", {7'd0, out_valid}, {7'd0, has});
    checkOutput("busy", {7'd0, busy}, {7'd0, has});
    checkOutput("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
    checkOutput("zero_drop", {7'd0, zero_drop}, {7'd0, zd_model});
    if (has) begin
      checkOutput("out_code", {5'd0, out_code}, 8'(code_q[0]));
      checkOutput("out_last", {7'd0, out_last}, {7'd0, last});
    end
    fire = has && rdy;
    acc  = v && exp_rdy;
    @(posedge clk);
    if (fire) void'(code_q.pop_front());
    zd_model = acc && (vec == 8'h00);
    if (acc && (vec != 8'h00)) pushCodes(vec);
  endtask

  // Asserts reset between clock edges.
  // Checks that the outputs clear at once, before any clock edge.
  // Then releases reset on a falling edge.
  task automatic doReset();
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_out_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("rst_out_code", {5'd0, out_code}, 8'h00);
    checkOutput("rst_out_last", {7'd0, out_last}, 8'h00);
    checkOutput("rst_zero_drop", {7'd0, zero_drop}, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'h00);
    checkOutput("rst_in_ready", {7'd0, in_ready}, 8'h01);
    code_q.delete();
    zd_model = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b0;
    doReset();

    // Single bit: one beat, then busy falls.
    applyStimulus(1'b1, 8'b0000_0100, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    // Three bits, consecutive codes.
    applyStimulus(1'b1, 8'b1010_0010, 1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // All bits set, with backpressure toggling 1,0,1,0.
    applyStimulus(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, (i % 2) == 0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    // Zero vector is dropped with a one-cycle pulse.
    applyStimulus(1'b1, 8'h00, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    // Back-to-back vectors, accepted on the last-beat edge.
    applyStimulus(1'b1, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h80, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a scan, then a fresh vector.
    applyStimulus(1'b1, 8'hF0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    doReset();
    applyStimulus(1'b1, 8'h08, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    // Randomised traffic: about 20% zero vectors, random backpressure.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] rv;
      rv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus($urandom_range(0, 1) == 1, rv, $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_8to3_scan.md
Name: enc_8to3_scan

Overview:
- Sequential 8-to-3 encoder. It is the return path for the 3-to-8 decoder: it turns one-hot or multi-hot 8-bit vectors back into 3-bit indices.
- It accepts a vector over a valid/ready handshake, then emits one 3-bit code per set bit, lowest index first, over a second valid/ready handshake.
- It sits between request/flag sources (buttons, decoder outputs, interrupt lines) and logic that consumes binary indices.

Parameters:
- IN_W, 8, input vector width. Fixed at 8 for this block; any other value is out of scope.
- OUT_W, 3, code width; equals clog2(IN_W).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_vec is valid.
- in_ready, output, 1, block can accept a vector this cycle.
- in_vec, input, 8, request vector; bit i means code i.
- out_valid, output, 1, out_code is valid.
- out_ready, input, 1, downstream accepts out_code.
- out_code, output, 3, index of the current set bit.
- out_last, output, 1, out_code is the final set bit of the current vector.
- zero_drop, output, 1, one-cycle pulse: an all-zero vector was accepted and discarded.
- busy, output, 1, high while the state is SCAN.

Behaviour:
Reset:
- One clock, clk. Asynchronous active-high reset rst; asserting rst immediately forces all state.
- Reset values: state=IDLE, pending=8'h00, out_valid=0, out_code=0, out_last=0, zero_drop=0, busy=0.
- in_ready=1 once reset is released.

State machine:
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready with in_vec!=0: pending<=in_vec, go to SCAN.
  - On in_valid&&in_ready with in_vec==0: stay in IDLE; zero_drop=1 on the next cycle only.
- SCAN:
  - out_valid=1.
  - out_code = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid&&out_ready with out_last=0: clear that bit in pending, stay in SCAN.
  - On out_valid&&out_ready with out_last=1: pending<=0, go to IDLE.
- out_valid, out_code and out_last are decoded only from registered state and pending; there is no combinational path from in_vec to any output.

Handshake rules:
- In SCAN, in_ready = out_valid && out_ready && out_last. This allows back-to-back vectors with no idle cycle.
- If a new vector is accepted on the same edge as the last handshake, pending loads the new vector and the state stays in SCAN; a zero vector in that case pulses zero_drop and returns to IDLE.
- out_code and out_last hold stable while out_valid=1 and out_ready=0.
- in_vec is ignored when in_ready=0.

Timing:
- Latency: vector accepted at edge N gives the first out_valid in cycle N+1.
- A vector with k set bits needs k out-handshakes; maximum throughput is one code per cycle.

Reset mid-SCAN:
- pending is discarded and no further codes are emitted.
- After release, state is IDLE and the block accepts a new vector.

Optional Feature:
- Macro: ENC_MSB_FIRST_EN.
- Defined: scan order is reversed. out_code is the highest set bit of pending, and out_last is unchanged in meaning (the final remaining bit).
- Undefined: lowest set bit first, as specified above.
- Ports, latency and handshake rules are identical in both builds.

Decomposition:
- Package enc_pkg holds:
  - constants ENC_IN_W=8 and ENC_OUT_W=3;
  - state encoding ST_IDLE=1'b0, ST_SCAN=1'b1;
  - a one-hot-to-index lookup function for reuse by benches.
- One combinational sub-module, pri_enc8:
  - input vec[7:0];
  - outputs idx[2:0], onehot[7:0] (the selected bit), single (exactly one bit set);
  - the scan direction is selected by ENC_MSB_FIRST_EN inside pri_enc8.
- The top level contains the FSM, the pending register and the handshakes.

Test Plan:
- Reset, then in_vec=8'b0000_0100 with out_ready=1 -> one beat, out_code=2, out_last=1; busy falls the following cycle.
- in_vec=8'b1010_0010 with out_ready=1 -> codes 1,5,7 on consecutive cycles, out_last only on 7. With ENC_MSB_FIRST_EN defined: codes 7,5,1.
- in_vec=8'hFF with out_ready toggling 1,0,1,0 -> codes 0..7 each held stable while out_ready=0; 8 handshakes total.
- in_vec=8'h00 -> zero_drop one-cycle pulse, out_valid never rises, in_ready stays 1.
- in_valid held high with vectors 8'h01 then 8'h80 -> the second vector is accepted on the last-beat edge; codes 0 then 7 on consecutive cycles with no gap.
- Assert rst mid-scan of 8'hF0 after code 4 -> outputs return to reset values immediately. After release, in_vec=8'h08 -> code 3 only.
